// File: rtl/regfile_2r1w.sv
// Two-read / one-write integer register file with write-through bypass and x0 tied to zero.
// Storage is cleared by a post-reset sweep; define REGFILE_DBG_EN to add a read-only debug port.
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
`ifdef REGFILE_DBG_EN
    input  logic [ADDR_W-1:0] dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
`endif
    output logic              ready_o
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // The sweep owns the single write port during INIT, so WB writes are dropped there.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            if (clr_ptr_q == LAST_IDX) begin
                state_d = ST_RUN;
            end else begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
        end else begin
            mem_we = we_i && (waddr_i != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (state_q == ST_RUN && re && raddr != '0) begin
            if (we_i && waddr_i == raddr) begin
                val = wdata_i;
            end else begin
                val = mem[raddr];
            end
        end
        return val;
    endfunction

    assign rdata1_o = read_port(re1_i, raddr1_i);
    assign rdata2_o = read_port(re2_i, raddr2_i);
    assign ready_o  = (state_q == ST_RUN);

`ifdef REGFILE_DBG_EN
    // Debug view shows committed array contents only; no bypass of the in-flight write.
    assign dbg_rdata_o = (state_q == ST_RUN && dbg_raddr_i != '0) ? mem[dbg_raddr_i] : '0;
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: expectations are queued as stimulus is driven
// and drained against the DUT outputs on the falling edge of the same cycle.
module tb_regfile_2r1w;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              we_i = 1'b0;
    logic [ADDR_W-1:0] waddr_i = '0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic              re1_i = 1'b0;
    logic [ADDR_W-1:0] raddr1_i = '0;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i = 1'b0;
    logic [ADDR_W-1:0] raddr2_i = '0;
    logic [DATA_W-1:0] rdata2_o;
    logic              ready_o;
    logic [ADDR_W-1:0] dbg_raddr_i = '0;
`ifdef REGFILE_DBG_EN
    logic [DATA_W-1:0] dbg_rdata_o;
`endif

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREG)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
`ifdef REGFILE_DBG_EN
        .dbg_raddr_i(dbg_raddr_i),
        .dbg_rdata_o(dbg_rdata_o),
`endif
        .ready_o    (ready_o)
    );

    typedef struct {
        string       tag;
        int          src;   // 0: rdata1, 1: rdata2, 2: ready, 3: debug
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [NREG];
    int          init_left = 31;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_step = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic rdy, input logic re, input logic [4:0] ra,
                                             input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (!rdy || !re || ra == 5'd0) return 32'h0;
        if (we && wa == ra) return wd;
        return model[ra];
    endfunction

    task automatic step(input string tag, input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic re1, input logic [4:0] ra1,
                        input logic re2, input logic [4:0] ra2);
        logic rdy;
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = rst; we_i = we; waddr_i = wa; wdata_i = wd;
        re1_i = re1; raddr1_i = ra1; re2_i = re2; raddr2_i = ra2;
        if (!rst) begin
            init_left = 31;
            for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        end
        rdy = rst && (init_left == 0);
        e.tag = {tag, ".rd1"};  e.src = 0; e.exp = exp_read(rdy, re1, ra1, we, wa, wd); sb_q.push_back(e);
        e.tag = {tag, ".rd2"};  e.src = 1; e.exp = exp_read(rdy, re2, ra2, we, wa, wd); sb_q.push_back(e);
        e.tag = {tag, ".rdy"};  e.src = 2; e.exp = {31'h0, rdy};                         sb_q.push_back(e);
`ifdef REGFILE_DBG_EN
        e.tag = {tag, ".dbg"};  e.src = 3;
        e.exp = (rdy && dbg_raddr_i != 5'd0) ? model[dbg_raddr_i] : 32'h0;
        sb_q.push_back(e);
`endif
        // Commit what the next rising edge will do.
        if (rst && init_left > 0) init_left--;
        else if (rdy && we && wa != 5'd0) model[wa] = wd;

        @(negedge clk);
        n_step++;
        $display("[%0d] %s rst=%b we=%b wa=%0d wd=%h | r1(%b,%0d)=%h r2(%b,%0d)=%h rdy=%b",
                 n_step, tag, rst, we, wa, wd, re1, ra1, rdata1_o, re2, ra2, rdata2_o, ready_o);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.src)
                0: check(e.tag, rdata1_o, e.exp);
                1: check(e.tag, rdata2_o, e.exp);
                2: check(e.tag, {31'h0, ready_o}, e.exp);
`ifdef REGFILE_DBG_EN
                3: check(e.tag, dbg_rdata_o, e.exp);
`endif
                default: ;
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;

        // Held in reset: ready low, reads zero.
        for (int i = 0; i < 3; i++) step("rst", 1'b0, 1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 1'b1, 5'd9);

        // Release: 31 INIT cycles with a dropped write attempt to x3.
        for (int i = 0; i < 31; i++) step("init", 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'(i));

        // All 32 addresses read zero after the sweep.
        for (int i = 0; i < 16; i++) step("clr", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i + 16));

        step("wr5",   1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step("rd5",   1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b0, 5'd0);
        step("wr0",   1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b1, 5'd0);
        step("rd0",   1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 1'b1, 5'd0);
        step("byp7",  1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
        step("rd7",   1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b1, 5'd7);
        step("re_off",1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd5, 1'b1, 5'd5);
        step("re_byp",1'b1, 1'b1, 5'd5, 32'h0102_0304, 1'b0, 5'd5, 1'b1, 5'd5);

        // Fill x1..x20, then reset mid-write.
        for (int i = 1; i <= 20; i++)
            step("fill", 1'b1, 1'b1, 5'(i), 32'(i) * 32'h1111_1111, 1'b1, 5'(i - 1), 1'b1, 5'(i));
        for (int i = 0; i < 2; i++) step("mid_rst", 1'b0, 1'b1, 5'd21, 32'h2222_2222, 1'b1, 5'd1, 1'b1, 5'd2);
        for (int i = 0; i < 31; i++) step("reinit", 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd1);
        for (int i = 0; i < 16; i++) step("reclr", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));

`ifdef REGFILE_DBG_EN
        dbg_raddr_i = 5'd9;
        step("dbg_wr9", 1'b1, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd9, 1'b0, 5'd0);
        step("dbg_rd9", 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0);
`endif

        // Random traffic biased toward address collisions.
        for (int i = 0; i < 150; i++) begin
            logic [4:0] wa, a1, a2;
            wa = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            dbg_raddr_i = 5'($urandom_range(0, 7));
            step("rand", 1'b1, 1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0), a1,
                 1'($urandom_range(0, 3) != 0), a2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
